// File: rtl/mem_bist.sv
// March-style memory self-test: two write/read sweeps, second one with
// inverted data, pipelined read compares and sticky pass/fail results.
module mem_bist #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [4:0]            err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_LAST,
        S_DONE
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] exp_word(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  p
    );
        logic [DATA_WIDTH-1:0] w;
        w = PATTERN ^ DATA_WIDTH'(a);
        return p ? ~w : w;
    endfunction

    state_e                state_q, state_d;
    logic                  p_q, p_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  r_en_q, r_en_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic [4:0]            err_q, err_d;

    // Read data lags the read strobe by one cycle; these track what is in flight.
    logic                  cmp_v_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;

    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  cnt_last;
    logic                  mismatch;

    assign cnt_nxt  = cnt_q + ADDR_WIDTH'(1);
    assign cnt_last = (cnt_q == {ADDR_WIDTH{1'b1}});
    assign mismatch = cmp_v_q && (mem_r_data != exp_word(cmp_addr_q, p_q));

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        w_en_d   = 1'b0;
        w_addr_d = '0;
        w_data_d = '0;
        r_en_d   = 1'b0;
        r_addr_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WRITE;
                    p_d      = 1'b0;
                    cnt_d    = '0;
                    w_en_d   = 1'b1;
                    w_data_d = exp_word('0, 1'b0);
                end
            end
            S_WRITE: begin
                if (cnt_last) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    r_en_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_nxt;
                    w_en_d   = 1'b1;
                    w_addr_d = cnt_nxt;
                    w_data_d = exp_word(cnt_nxt, p_q);
                end
            end
            S_READ: begin
                if (cnt_last) begin
                    state_d = S_LAST;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_nxt;
                    r_en_d   = 1'b1;
                    r_addr_d = cnt_nxt;
                end
            end
            S_LAST: begin
                if (!p_q) begin
                    state_d  = S_WRITE;
                    p_d      = 1'b1;
                    cnt_d    = '0;
                    w_en_d   = 1'b1;
                    w_data_d = exp_word('0, 1'b1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                p_d     = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                p_d     = 1'b0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_WRITE) || (state_d == S_READ) ||
                 (state_d == S_LAST);
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        err_d  = err_q;
        if ((state_q == S_IDLE) && start) begin
            pass_d = 1'b1;
            fail_d = '0;
            err_d  = '0;
        end else if (mismatch) begin
            pass_d = 1'b0;
            // err_q is still zero only before the first mismatch of a run
            if (err_q == 5'd0) begin
                fail_d = cmp_addr_q;
            end
            if (err_q != 5'd31) begin
                err_d = err_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            p_q        <= 1'b0;
            cnt_q      <= '0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            r_en_q     <= 1'b0;
            r_addr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            err_q      <= '0;
            cmp_v_q    <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            r_en_q     <= r_en_d;
            r_addr_q   <= r_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            cmp_v_q    <= r_en_q;
            cmp_addr_q <= r_addr_q;
        end
    end

    assign mem_w_en   = w_en_q;
    assign mem_w_addr = w_addr_q;
    assign mem_w_data = w_data_q;
    assign mem_r_en   = r_en_q;
    assign mem_r_addr = r_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: faulty-memory model plus a sweep-level reference of
// expected port activity and results.
module tb_mem_bist;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [4:0]    err_count;

    int ncmp = 0;
    int nerr = 0;

    // memory fault configuration
    logic [DW-1:0] mem [DEPTH];
    bit            sa_en   = 1'b0;
    int            sa_addr = 0;
    int            sa_bit  = 0;
    bit            sa_val  = 1'b0;
    logic [AW-1:0] tie     = '0;

    mem_bist #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PATTERN   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_w_en  (w_en),
        .mem_w_addr(w_addr),
        .mem_w_data(w_data),
        .mem_r_en  (r_en),
        .mem_r_addr(r_addr),
        .mem_r_data(r_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] faulty(input int ra, input logic [DW-1:0] v);
        logic [DW-1:0] x;
        x = v;
        if (sa_en && ra == sa_addr) x[sa_bit] = sa_val;
        return x;
    endfunction

    // Read data outside compare cycles is garbage on purpose.
    always @(posedge clk) begin
        if (w_en) mem[w_addr & ~tie] <= w_data;
        if (r_en) r_data <= faulty(int'(r_addr & ~tie), mem[r_addr & ~tie]);
        else      r_data <= DW'($urandom);
    end

    function automatic logic [DW-1:0] ev(input int a, input int p);
        logic [DW-1:0] x;
        x = 8'hA5 ^ DW'(a);
        return (p != 0) ? ~x : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two sweeps over a memory array, applying the same faults as the model memory.
    task automatic ref_model(output bit rp, output int rfa, output int rec);
        logic [DW-1:0] m [DEPTH];
        int            tm;
        int            ra;
        logic [DW-1:0] v;
        tm  = int'(tie);
        rp  = 1'b1;
        rfa = 0;
        rec = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) m[a & ~tm] = ev(a, p);
            for (int a = 0; a < DEPTH; a++) begin
                ra = a & ~tm;
                v  = faulty(ra, m[ra]);
                if (v !== ev(a, p)) begin
                    if (rp) rfa = a;
                    rp = 1'b0;
                    if (rec < 31) rec++;
                end
            end
        end
    endtask

    // t = cycles after the edge that sampled start; each pass spans 33 cycles.
    task automatic chk_cycle(input int t);
        int pos;
        int p;
        bit ew;
        bit er;
        pos = 0;
        p   = 0;
        ew  = 1'b0;
        er  = 1'b0;
        if (t < 66) begin
            pos = t % 33;
            p   = t / 33;
            ew  = (pos < 16);
            er  = (pos >= 16) && (pos < 32);
        end
        chk("w_en", w_en, ew);
        chk("w_addr", w_addr, ew ? pos : 0);
        chk("w_data", w_data, ew ? ev(pos, p) : 0);
        chk("r_en", r_en, er);
        chk("r_addr", r_addr, er ? pos - 16 : 0);
        chk("busy", busy, t < 66);
        chk("done", done, t == 66);
        chk("excl", w_en & r_en, 0);
    endtask

    task automatic full_run(input int pa, input int pb);
        bit rp;
        int rfa;
        int rec;
        ref_model(rp, rfa, rec);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= 68; t++) begin
            chk_cycle(t);
            if (t == 66 || t == 68) begin
                chk("pass", pass, rp);
                chk("fail_addr", fail_addr, rfa);
                chk("err_count", err_count, rec);
            end
            start = (t == pa) || (t == pb);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_w_en", w_en, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_r_en", r_en, 0);
        chk("rst_r_addr", r_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_err", err_count, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // fault-free
        full_run(-1, -1);

        // addr 5 bit 0 stuck-at-0
        sa_en   = 1'b1;
        sa_addr = 5;
        sa_bit  = 0;
        sa_val  = 1'b0;
        full_run(-1, -1);
        chk("sa_fail_addr", fail_addr, 5);
        chk("sa_err", err_count, 1);

        // address bit 3 tied low on both ports
        sa_en = 1'b0;
        tie   = 4'h8;
        full_run(-1, -1);
        chk("tie_err", err_count, 16);

        // stray start pulses mid-run
        tie = '0;
        full_run(5, 40);

        // abort by reset 20 cycles into a run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_w_en", w_en, 0);
        chk("abort_r_en", r_en, 0);
        chk("abort_err", err_count, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            chk("post_abort_done", done, 0);
            chk("post_abort_en", w_en | r_en, 0);
        end
        full_run(-1, -1);
        chk("after_abort_pass", pass, 1);

        // start held high restarts from the IDLE cycle after DONE
        start = 1'b1;
        @(negedge clk);
        for (int t = 0; t <= 67; t++) begin
            chk_cycle(t);
            @(negedge clk);
        end
        chk("restart_busy", busy, 1);
        chk("restart_w_en", w_en, 1);
        chk("restart_w_addr", w_addr, 0);
        chk("restart_w_data", w_data, 8'hA5);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // randomized fault configurations and stray starts
        for (int k = 0; k < 8; k++) begin
            sa_en   = bit'($urandom_range(0, 1));
            sa_addr = int'($urandom_range(0, DEPTH - 1));
            sa_bit  = int'($urandom_range(0, DW - 1));
            sa_val  = bit'($urandom_range(0, 1));
            tie     = ($urandom_range(0, 2) == 0) ? AW'(1 << $urandom_range(0, AW - 1)) : '0;
            full_run(int'($urandom_range(1, 64)), int'($urandom_range(1, 64)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, memory address width (depth = 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 SHALL have parameter PATTERN, default 8'hA5, base test pattern.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start, input, 1, request test run; sampled only in IDLE.
REQ-007 SHALL have port mem_w_en, output, 1, memory write enable.
REQ-008 SHALL have port mem_w_addr, output, ADDR_WIDTH, memory write address.
REQ-009 SHALL have port mem_w_data, output, DATA_WIDTH, memory write data.
REQ-010 SHALL have port mem_r_en, output, 1, memory read enable.
REQ-011 SHALL have port mem_r_addr, output, ADDR_WIDTH, memory read address.
REQ-012 SHALL have port mem_r_data, input, DATA_WIDTH, memory read data, valid 1 cycle after mem_r_en.
REQ-013 SHALL have port busy, output, 1, test in progress.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port pass, output, 1, result: 1 = no mismatches; held until next start.
REQ-016 SHALL have port fail_addr, output, ADDR_WIDTH, address of first mismatch; held until next start.
REQ-017 SHALL have port err_count, output, 5, mismatch count, saturating at 31; held until next start.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, LAST, DONE, plus a 1-bit pass index p (0, 1).
REQ-020 Expected word for address a SHALL be E(a,p) = PATTERN ^ zero-extended a when p=0, and its bitwise inverse when p=1.
REQ-021 IDLE with start=1 at an edge SHALL go to WRITE, with p=0, address counter=0, err_count=0, pass=1 and fail_addr=0.
REQ-022 WRITE SHALL assert mem_w_en for one cycle per address, ascending 0..depth-1, with mem_w_data=E(addr,p); after the last address it SHALL go to READ.
REQ-023 READ SHALL assert mem_r_en for one cycle per address, ascending 0..depth-1; after the last address it SHALL go to LAST.
REQ-024 Each read SHALL be compared against the expected value delayed one cycle, so compares are pipelined and the final compare occurs in LAST.
REQ-025 LAST SHALL go to WRITE with p=1 when p=0, and to DONE when p=1.
REQ-026 A mismatch SHALL set pass=0, increment err_count (saturating at 31), and latch fail_addr only on the first mismatch of the run.
REQ-027 DONE SHALL drive done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in WRITE, READ and LAST.
REQ-029 With depth 16, start sampled at edge E0: busy SHALL be high after E0 through E66, and done SHALL be high after E66 only.
REQ-030 mem_w_en and mem_r_en SHALL never be high in the same cycle.
REQ-031 When mem_w_en=0, mem_w_addr and mem_w_data SHALL be 0; when mem_r_en=0, mem_r_addr SHALL be 0.
REQ-032 start SHALL be ignored in every state except IDLE.
REQ-033 start held high SHALL begin a new run on the IDLE cycle after DONE.
REQ-034 mem_r_data SHALL be ignored except on a compare cycle.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, p=0, counters=0, mem_w_en=mem_r_en=0, all addresses and data=0, busy=0, done=0, pass=0, fail_addr=0 and err_count=0, overriding start.
REQ-036 rst asserted mid-run SHALL abort the run with no done pulse, and the memory SHALL see no further enables.

Verification
REQ-037 Fault-free 16x8 memory model, 1-cycle start pulse -> done after E66, pass=1, err_count=0; 16 writes then 16 reads per pass; write data addr 0 = A5, addr 5 = A0; pass-1 addr 0 = 5A.
REQ-038 Addr 5 bit 0 stuck-at-0 -> pass=0, fail_addr=5, err_count=1, failing in pass 1 (expected 5F).
REQ-039 Address bit 3 tied 0 on both ports -> pass=0, fail_addr=0, err_count=16 (addresses 0..7 mismatch in each pass).
REQ-040 rst asserted 20 cycles after start -> next cycle busy=0, enables=0, err_count=0, and no done pulse; a following start completes with pass=1.
REQ-041 start pulsed again at cycles 5 and 40 of a run -> ignored, exactly one done pulse, 66-cycle timing unchanged.
REQ-042 Enable and idle-port checks on every cycle -> mem_w_en and mem_r_en never both high; idle ports are zero.
